// File: rtl/dat_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dat_mem_pkg
//  Description : Shared operation and state encodings for the data memory
//                with hardware stack.
//  Revision    : 1.0  initial release
// ============================================================================
package dat_mem_pkg;

    // Operation codes presented by the decode stage; codes 5-7 behave as NOP
    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_LOAD  = 3'd1,
        OP_STORE = 3'd2,
        OP_PUSH  = 3'd3,
        OP_POP   = 3'd4
    } op_e;

    // Controller states: post-reset zeroing sweep, then normal service
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/dat_mem_stk_sp_ram.sv
`default_nettype none
// ============================================================================
//  Module      : sp_ram
//  Description : DW x 2**AW storage array, synchronous write port and
//                combinational read port. Contents have no reset.
//  Revision    : 1.0  initial release
// ============================================================================
module sp_ram #(
    parameter int DW       = 8,
    parameter int AW       = 8,
    parameter int TRACE_EN = 0
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    localparam int C_DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [C_DEPTH];

    // Single write port; all writers are muxed in the parent
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

`ifndef SYNTHESIS
    // Optional simulation trace of every committed write
    always_ff @(posedge clk) begin
        if ((TRACE_EN != 0) && we_i) begin
            $display("sp_ram: write [%0h] <= %0h", waddr_i, wdata_i);
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/dat_mem_stk.sv
`default_nettype none
// ============================================================================
//  Module      : dat_mem_stk
//  Description : Single-port data RAM with a hardware stack in its top
//                STK_DEPTH words, registered reads, sticky overflow /
//                underflow flags and a post-reset zeroing sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module dat_mem_stk
    import dat_mem_pkg::*;
#(
    parameter int DW        = 8,
    parameter int AW        = 8,
    parameter int STK_DEPTH = 16,
    parameter int TRACE_EN  = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [2:0]    op_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] dat_in_i,
    input  logic          err_clr_i,
    output logic [DW-1:0] dat_out_o,
    output logic          rvalid_o,
    output logic          busy_o,
    output logic [AW:0]   stk_cnt_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          ovf_o,
    output logic          udf_o
);

    localparam int            C_DEPTH     = 1 << AW;
    localparam logic [AW:0]   C_DEPTH_W   = (AW+1)'(C_DEPTH);
    localparam logic [AW:0]   C_STK_LIMIT = (AW+1)'(STK_DEPTH);
    localparam logic [AW-1:0] C_LAST_ADDR = '1;

    // Registered state
    state_e        state_q,   state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic          busy_q,    busy_d;
    logic [DW-1:0] dat_out_q, dat_out_d;
    logic          rvalid_q,  rvalid_d;
    logic [AW:0]   stk_cnt_q, stk_cnt_d;
    logic          full_q,    full_d;
    logic          empty_q,   empty_d;
    logic          ovf_q,     ovf_d;
    logic          udf_q,     udf_d;

    // Decoded, qualified operations
    logic w_run;
    logic w_load;
    logic w_store;
    logic w_push_ok;
    logic w_push_ovf;
    logic w_pop_ok;
    logic w_pop_udf;

    // RAM port signals
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [DW-1:0] w_wdata;
    logic [AW-1:0] w_raddr;
    logic [DW-1:0] w_rdata;

    assign w_run      = (state_q == ST_RUN);
    assign w_load     = w_run && (op_i == OP_LOAD);
    assign w_store    = w_run && (op_i == OP_STORE);
    assign w_push_ok  = w_run && (op_i == OP_PUSH) && !full_q;
    assign w_push_ovf = w_run && (op_i == OP_PUSH) &&  full_q;
    assign w_pop_ok   = w_run && (op_i == OP_POP)  && !empty_q;
    assign w_pop_udf  = w_run && (op_i == OP_POP)  &&  empty_q;

    // Top of stack lives at DEPTH-cnt; the count never reaches 0 when used
    assign w_raddr = w_pop_ok ? AW'(C_DEPTH_W - stk_cnt_q) : addr_i;

    // Write-port arbitration: the clear sweep owns the port while busy
    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = '0;
        if (state_q == ST_CLEAR) begin
            w_we    = 1'b1;
            w_waddr = clr_cnt_q;
        end else if (w_store) begin
            w_we    = 1'b1;
            w_waddr = addr_i;
            w_wdata = dat_in_i;
        end else if (w_push_ok) begin
            // Push below the current top; count < STK_DEPTH <= DEPTH here
            w_we    = 1'b1;
            w_waddr = C_LAST_ADDR - stk_cnt_q[AW-1:0];
            w_wdata = dat_in_i;
        end
    end

    sp_ram #(
        .DW       (DW),
        .AW       (AW),
        .TRACE_EN (TRACE_EN)
    ) u_sp_ram (
        .clk     (clk),
        .we_i    (w_we),
        .waddr_i (w_waddr),
        .wdata_i (w_wdata),
        .raddr_i (w_raddr),
        .rdata_o (w_rdata)
    );

    // Next-state computation for the controller, read path and stack
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        busy_d    = busy_q;
        dat_out_d = dat_out_q;
        rvalid_d  = 1'b0;
        stk_cnt_d = stk_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == C_LAST_ADDR) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b0;
                end
            end
            ST_RUN: begin
                if (w_load || w_pop_ok) begin
                    dat_out_d = w_rdata;
                    rvalid_d  = 1'b1;
                end
                if (w_push_ok) begin
                    stk_cnt_d = stk_cnt_q + 1'b1;
                end else if (w_pop_ok) begin
                    stk_cnt_d = stk_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                busy_d  = 1'b1;
            end
        endcase
        // Sticky flags: a new error outranks a simultaneous clear
        ovf_d   = w_push_ovf ? 1'b1 : (err_clr_i ? 1'b0 : ovf_q);
        udf_d   = w_pop_udf  ? 1'b1 : (err_clr_i ? 1'b0 : udf_q);
        full_d  = (stk_cnt_d == C_STK_LIMIT);
        empty_d = (stk_cnt_d == '0);
    end

    // State registers; async reset restarts the clear sweep from address 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
            dat_out_q <= '0;
            rvalid_q  <= 1'b0;
            stk_cnt_q <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            busy_q    <= busy_d;
            dat_out_q <= dat_out_d;
            rvalid_q  <= rvalid_d;
            stk_cnt_q <= stk_cnt_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    assign dat_out_o = dat_out_q;
    assign rvalid_o  = rvalid_q;
    assign busy_o    = busy_q;
    assign stk_cnt_o = stk_cnt_q;
    assign full_o    = full_q;
    assign empty_o   = empty_q;
    assign ovf_o     = ovf_q;
    assign udf_o     = udf_q;

endmodule
`default_nettype wire

// File: tb/tb_dat_mem_stk.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dat_mem_stk
//  Description : Self-checking bench for dat_mem_stk (DW=8, AW=8,
//                STK_DEPTH=16): vector table, corner sequences and a
//                randomized run against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dat_mem_stk;

    localparam int DW        = 8;
    localparam int AW        = 8;
    localparam int STK_DEPTH = 16;
    localparam int MEMSZ     = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    op_i;
    logic [AW-1:0] addr_i;
    logic [DW-1:0] dat_in_i;
    logic          err_clr_i;
    logic [DW-1:0] dat_out_o;
    logic          rvalid_o;
    logic          busy_o;
    logic [AW:0]   stk_cnt_o;
    logic          full_o;
    logic          empty_o;
    logic          ovf_o;
    logic          udf_o;

    always #5 clk = ~clk;

    dat_mem_stk #(
        .DW        (DW),
        .AW        (AW),
        .STK_DEPTH (STK_DEPTH),
        .TRACE_EN  (0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_i      (op_i),
        .addr_i    (addr_i),
        .dat_in_i  (dat_in_i),
        .err_clr_i (err_clr_i),
        .dat_out_o (dat_out_o),
        .rvalid_o  (rvalid_o),
        .busy_o    (busy_o),
        .stk_cnt_o (stk_cnt_o),
        .full_o    (full_o),
        .empty_o   (empty_o),
        .ovf_o     (ovf_o),
        .udf_o     (udf_o)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Behavioural model: plain memory image plus a stack depth count
    int m_mem [MEMSZ];
    int m_cnt;
    int m_dout;
    int m_rv;
    int m_ovf;
    int m_udf;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic void model_cleared();
        for (int i = 0; i < MEMSZ; i++) m_mem[i] = 0;
        m_cnt = 0; m_dout = 0; m_rv = 0; m_ovf = 0; m_udf = 0;
    endfunction

    function automatic void model_apply(input int op, input int addr, input int din, input int clr);
        int set_o = 0;
        int set_u = 0;
        m_rv = 0;
        if (op == 1) begin
            m_dout = m_mem[addr]; m_rv = 1;
        end else if (op == 2) begin
            m_mem[addr] = din;
        end else if (op == 3) begin
            if (m_cnt == STK_DEPTH) set_o = 1;
            else begin m_mem[MEMSZ - 1 - m_cnt] = din; m_cnt++; end
        end else if (op == 4) begin
            if (m_cnt == 0) set_u = 1;
            else begin m_dout = m_mem[MEMSZ - m_cnt]; m_cnt--; m_rv = 1; end
        end
        if (set_o != 0) m_ovf = 1; else if (clr != 0) m_ovf = 0;
        if (set_u != 0) m_udf = 1; else if (clr != 0) m_udf = 0;
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".dout"},  int'(dat_out_o), m_dout);
        chk({tag, ".rv"},    int'(rvalid_o),  m_rv);
        chk({tag, ".cnt"},   int'(stk_cnt_o), m_cnt);
        chk({tag, ".full"},  int'(full_o),    int'(m_cnt == STK_DEPTH));
        chk({tag, ".empty"}, int'(empty_o),   int'(m_cnt == 0));
        chk({tag, ".ovf"},   int'(ovf_o),     m_ovf);
        chk({tag, ".udf"},   int'(udf_o),     m_udf);
        chk({tag, ".busy"},  int'(busy_o),    0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".dout"},  int'(dat_out_o), 0);
        chk({tag, ".rv"},    int'(rvalid_o),  0);
        chk({tag, ".busy"},  int'(busy_o),    1);
        chk({tag, ".cnt"},   int'(stk_cnt_o), 0);
        chk({tag, ".empty"}, int'(empty_o),   1);
        chk({tag, ".full"},  int'(full_o),    0);
        chk({tag, ".ovf"},   int'(ovf_o),     0);
        chk({tag, ".udf"},   int'(udf_o),     0);
    endtask

    // Drive one op, let one edge accept it, then compare with the model
    task automatic step(input int op, input int addr, input int din, input int clr, input string tag);
        op_i = 3'(op); addr_i = 8'(addr); dat_in_i = 8'(din); err_clr_i = 1'(clr);
        @(posedge clk); #1;
        model_apply(op, addr, din, clr);
        check_model(tag);
    endtask

    // Release reset, present a store during the sweep, count busy edges
    task automatic release_and_clear(input string tag, input int abort_after);
        int n = 0;
        int rv_seen = 0;
        op_i = 3'd2; addr_i = 8'h20; dat_in_i = 8'hFF; err_clr_i = 1'b0;
        rst_n = 1'b1;
        chk({tag, ".busy_at_release"}, int'(busy_o), 1);
        while (busy_o && n < 400) begin
            @(posedge clk); #1;
            n++;
            if (rvalid_o) rv_seen = 1;
            if (abort_after > 0 && n == abort_after) break;
        end
        if (abort_after == 0) begin
            chk({tag, ".clear_edges"}, n, 256);
            chk({tag, ".no_rvalid_busy"}, rv_seen, 0);
        end
        op_i = 3'd0;
    endtask

    typedef struct {
        int op; int addr; int din;
        int e_dout; int e_rv; int e_cnt; int e_udf;
    } vec_t;

    vec_t vt [15];

    initial begin
        vt[0]  = '{1, 8'h00, 0,     8'h00, 1, 0, 0};
        vt[1]  = '{1, 8'h80, 0,     8'h00, 1, 0, 0};
        vt[2]  = '{1, 8'hFF, 0,     8'h00, 1, 0, 0};
        vt[3]  = '{2, 8'h10, 8'hA5, 8'h00, 0, 0, 0};
        vt[4]  = '{1, 8'h10, 0,     8'hA5, 1, 0, 0};
        vt[5]  = '{0, 8'h10, 0,     8'hA5, 0, 0, 0};
        vt[6]  = '{3, 8'h00, 1,     8'hA5, 0, 1, 0};
        vt[7]  = '{3, 8'h00, 2,     8'hA5, 0, 2, 0};
        vt[8]  = '{3, 8'h00, 3,     8'hA5, 0, 3, 0};
        vt[9]  = '{1, 8'hFF, 0,     8'h01, 1, 3, 0};
        vt[10] = '{4, 8'h00, 0,     8'h03, 1, 2, 0};
        vt[11] = '{4, 8'h00, 0,     8'h02, 1, 1, 0};
        vt[12] = '{4, 8'h00, 0,     8'h01, 1, 0, 0};
        vt[13] = '{5, 8'h00, 8'h77, 8'h01, 0, 0, 0};
        vt[14] = '{7, 8'h10, 8'h77, 8'h01, 0, 0, 0};

        // Reset state, then the full clear sweep with an op held during busy
        rst_n = 1'b0; op_i = 3'd0; addr_i = '0; dat_in_i = '0; err_clr_i = 1'b0;
        #12;
        check_reset_vals("reset");
        @(negedge clk);
        release_and_clear("clr0", 0);
        model_cleared();
        step(1, 8'h20, 0, 0, "busy_store_ignored");
        chk("busy_store_data", int'(dat_out_o), 0);

        // Vector table
        for (int i = 0; i < 15; i++) begin
            op_i = 3'(vt[i].op); addr_i = 8'(vt[i].addr); dat_in_i = 8'(vt[i].din); err_clr_i = 1'b0;
            @(posedge clk); #1;
            model_apply(vt[i].op, vt[i].addr, vt[i].din, 0);
            chk($sformatf("vec%0d.dout", i),  int'(dat_out_o), vt[i].e_dout);
            chk($sformatf("vec%0d.rv", i),    int'(rvalid_o),  vt[i].e_rv);
            chk($sformatf("vec%0d.cnt", i),   int'(stk_cnt_o), vt[i].e_cnt);
            chk($sformatf("vec%0d.empty", i), int'(empty_o),   int'(vt[i].e_cnt == 0));
            chk($sformatf("vec%0d.udf", i),   int'(udf_o),     vt[i].e_udf);
        end

        // Overflow: fill the stack, one extra push must not touch mem[239]
        step(2, 239, 8'h5A, 0, "ovf_store239");
        for (int i = 0; i < 16; i++) step(3, 0, 8'h10 + i, 0, "ovf_push");
        chk("ovf_full16", int'(full_o), 1);
        chk("ovf_not_yet", int'(ovf_o), 0);
        step(3, 0, 8'hEE, 0, "ovf_push17");
        chk("ovf_set", int'(ovf_o), 1);
        chk("ovf_cnt", int'(stk_cnt_o), 16);
        step(1, 239, 0, 0, "ovf_load239");
        chk("ovf_mem239", int'(dat_out_o), 8'h5A);
        step(3, 0, 8'hEE, 1, "ovf_set_wins");
        chk("ovf_set_wins_flag", int'(ovf_o), 1);
        step(0, 0, 0, 1, "ovf_clr");
        chk("ovf_cleared", int'(ovf_o), 0);

        // Underflow: drain, one extra pop leaves dat_out at the last value
        for (int i = 0; i < 16; i++) step(4, 0, 0, 0, "udf_pop");
        chk("udf_last_pop", int'(dat_out_o), 8'h10);
        step(4, 0, 0, 0, "udf_pop17");
        chk("udf_set", int'(udf_o), 1);
        chk("udf_dout_held", int'(dat_out_o), 8'h10);
        chk("udf_no_rvalid", int'(rvalid_o), 0);
        step(0, 0, 0, 1, "udf_clr");
        chk("udf_cleared", int'(udf_o), 0);

        // Reset mid-CLEAR
        @(posedge clk); #3;
        rst_n = 1'b0; #1;
        check_reset_vals("rst_run0");
        @(negedge clk);
        release_and_clear("abort", 100);
        #3; rst_n = 1'b0; #1;
        check_reset_vals("rst_midclear");
        @(negedge clk);
        release_and_clear("clr1", 0);
        model_cleared();
        check_model("after_clr1");

        // Reset mid-RUN with five words stacked
        step(2, 8'h33, 8'hC3, 0, "pre_store");
        step(1, 8'h33, 0, 0, "pre_load");
        for (int i = 0; i < 5; i++) step(3, 0, i + 1, 0, "pre_push");
        chk("pre_cnt5", int'(stk_cnt_o), 5);
        #2; rst_n = 1'b0; #1;
        check_reset_vals("rst_midrun");
        @(negedge clk);
        release_and_clear("clr2", 0);
        model_cleared();
        step(4, 0, 0, 0, "post_rst_pop");
        chk("post_rst_udf", int'(udf_o), 1);
        step(1, 8'h33, 0, 1, "post_rst_load");

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            int r  = $urandom_range(0, 99);
            int op = (r < 30) ? 3 : (r < 60) ? 4 : (r < 75) ? 1 : (r < 90) ? 2 : $urandom_range(0, 7);
            int ad = ($urandom_range(0, 3) == 0) ? $urandom_range(232, 255) : $urandom_range(0, 255);
            step(op, ad, $urandom_range(0, 255), int'($urandom_range(0, 9) == 0), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dat_mem_stk.md
# dat_mem_stk

Parametrised successor to the byte data memory: a single-port synchronous RAM of configurable width and depth with a hardware stack carved out of its top words. Registered loads and pops, push/pop pointer management, overflow and underflow flags, and a post-reset clear sequencer that zeroes every word. It sits beside the program counter and register file, serving load, store, push and pop instructions from the decode stage.

## Interface
- DW, 8, data word width in bits
- AW, 8, address width; DEPTH = 2**AW words
- STK_DEPTH, 16, words reserved for the stack, occupying addresses DEPTH-1 down to DEPTH-STK_DEPTH; legal range 1..DEPTH
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- op  in  3  operation: 0 NOP, 1 LOAD, 2 STORE, 3 PUSH, 4 POP; codes 5-7 act as NOP
- addr  in  AW  address for LOAD and STORE; ignored for PUSH and POP
- dat_in  in  DW  write data for STORE and PUSH
- err_clr  in  1  clears both sticky error flags
- dat_out  out  DW  registered read data
- rvalid  out  1  one-cycle pulse: dat_out is new
- busy  out  1  clear sequence in progress; op is ignored
- stk_cnt  out  AW+1  number of words currently on the stack
- full  out  1  stk_cnt == STK_DEPTH
- empty  out  1  stk_cnt == 0
- ovf  out  1  sticky: a PUSH was attempted while full
- udf  out  1  sticky: a POP was attempted while empty

## Operation
- The FSM has two states, CLEAR and RUN. The reset state is CLEAR.
- CLEAR:
  - An AW-bit counter starts at 0 and writes 0 to mem[counter] on each edge.
  - After writing DEPTH-1, the FSM goes to RUN.
  - busy = 1 throughout CLEAR; op is ignored.
- RUN: one op is accepted per edge.
  - LOAD latches mem[addr] into dat_out.
  - STORE writes dat_in to mem[addr]. Stores into the stack region are allowed and are not flagged.
  - PUSH when not full writes dat_in to mem[DEPTH-1-stk_cnt], then stk_cnt increments.
  - PUSH when full writes nothing; stk_cnt is unchanged; ovf is set.
  - POP when not empty latches mem[DEPTH-stk_cnt] (the top of stack) into dat_out, then stk_cnt decrements.
  - POP when empty reads nothing; dat_out and stk_cnt are unchanged; rvalid stays 0; udf is set.
- err_clr clears ovf and udf. If err_clr and an error-setting op occur in the same cycle, set wins.
- Write data, address and read data have exactly DW and AW bits. There is no wrap-around of the stack pointer, because the full/empty checks block it.
- Reset values: dat_out = 0, rvalid = 0, busy = 1, stk_cnt = 0, empty = 1, full = 0, ovf = 0, udf = 0.
- Memory contents are not touched by the async reset; the CLEAR sequence zeroes them.
- Asserting rst_n low mid-CLEAR or mid-RUN aborts immediately. CLEAR restarts from address 0 after release.

## Timing
- busy is 1 while rst_n is low.
- After rst_n rises, busy stays 1 for exactly DEPTH rising edges.
- busy falls on the edge that writes the last word. The op presented on the first edge with busy = 0 is accepted.
- Read latency is one cycle. For a LOAD or POP accepted on edge N:
  - dat_out is valid after edge N and held until the next LOAD or POP.
  - rvalid is 1 only between edges N and N+1.
- Writes commit on the accepting edge, so a LOAD of the same address on the next edge returns the new data.
- Back-to-back PUSH/POP on consecutive edges is supported at full rate.
- full, empty and stk_cnt are registered and reflect all ops accepted up to the last edge.
- ovf and udf assert after the offending edge.

## Structure
- The package dat_mem_pkg holds:
  - the op_e enum (NOP, LOAD, STORE, PUSH, POP);
  - the state_e enum (CLEAR, RUN);
  - no parameters, which stay on the module.
- One sub-module, sp_ram: a DW x DEPTH single-port array with a synchronous write port (we, waddr, wdata) and a combinational read port.
  - Clear-sequencer writes and op writes are muxed onto the single write port.
  - dat_out is registered in the top level.
- The $display write trace is kept inside sp_ram, under `ifndef SYNTHESIS.

## Test plan
All scenarios use DW = 8, AW = 8, STK_DEPTH = 16.
- Reset and clear: release rst_n -> busy = 1 for exactly 256 edges; afterwards LOAD of addresses 0, 128 and 255 each return 0 with rvalid pulsing once.
- Store/load: STORE 0xA5 to 0x10, then LOAD 0x10 on the next edge -> dat_out = 0xA5 one cycle later; a NOP cycle -> rvalid = 0 and dat_out held at 0xA5.
- Stack LIFO: PUSH 1, 2, 3 -> stk_cnt = 3 and mem[255] = 1; then POP three times -> dat_out 3, 2, 1; then empty = 1, udf = 0.
- Overflow/underflow: 17 PUSHes -> full = 1 after the 16th, ovf = 1 after the 17th, mem[239] unchanged; 17 POPs -> udf = 1 and dat_out retains the last valid value; err_clr -> both flags 0.
- Simultaneous events: err_clr together with a PUSH-when-full -> ovf = 1; an op presented during busy -> no write and no rvalid.
- Reset mid-operation: drop rst_n with stk_cnt = 5 mid-CLEAR and mid-RUN -> all outputs return to reset values immediately; CLEAR reruns the full 256 edges; the stack is empty afterwards.
